guard_dispatch_fsm: RTL and testbench

//  Parametrised guarded-resumption state machine: a multi-state tag register with priority-ordered

---
 rtl/guard_dispatch_fsm.sv | 118 +++++++++++
 tb/tb_guard_dispatch_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/guard_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module   : guard_dispatch_fsm
// Brief    : Guarded accumulator FSM; sums valid words, emits after LIMIT
//            words or on overflow, terminates on an MSB-flagged word.
//            Optional GUARD_DISPATCH_STALL_EN adds out_ready back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module guard_dispatch_fsm #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 4,
    parameter int LIMIT   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef GUARD_DISPATCH_STALL_EN
    input  logic              out_ready,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              cont
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_ACC   = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] c_cnt_last = COUNT_W'(LIMIT - 1);
    localparam logic [COUNT_W-1:0] c_cnt_one  = COUNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [COUNT_W-1:0]  r_cnt;
    logic [COUNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W:0]     w_sum;
    logic                w_emit_done;

    assign w_sum = {1'b0, r_acc} + {1'b0, in_data};

`ifdef GUARD_DISPATCH_STALL_EN
    assign w_emit_done = out_ready;
`else
    assign w_emit_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_START;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_START: begin
                if (in_valid) begin
                    if (in_data[DATA_W-1]) begin
                        w_state_nxt = S_DONE;
                    end else if (in_data != '0) begin
                        w_acc_nxt   = in_data;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = S_ACC;
                    end
                end
            end
            S_ACC: begin
                // Guard order matters: terminate beats overflow beats LIMIT.
                if (in_valid) begin
                    if (in_data[DATA_W-1]) begin
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else if (w_sum[DATA_W]) begin
                        w_acc_nxt   = '1;
                        w_state_nxt = S_EMIT;
                    end else if (r_cnt == c_cnt_last) begin
                        w_acc_nxt   = w_sum[DATA_W-1:0];
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_acc_nxt   = w_sum[DATA_W-1:0];
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
            end
            S_EMIT: begin
                if (w_emit_done) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_DONE;
            end
        endcase
    end

    assign out_valid = (r_state == S_EMIT);
    assign out_data  = out_valid ? r_acc : '0;
    assign cont      = (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_guard_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_guard_dispatch_fsm
// Brief    : Scoreboard bench for guard_dispatch_fsm (DATA_W=8, LIMIT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_guard_dispatch_fsm;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 4;
    localparam int LIMIT   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
`ifdef GUARD_DISPATCH_STALL_EN
    logic              out_ready;
`endif
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              cont;

    int                n_total = 0;
    int                n_bad   = 0;
    logic [DATA_W-1:0] sb_q[$];

    always #5 clk = ~clk;

    guard_dispatch_fsm #(
        .DATA_W (DATA_W),
        .COUNT_W(COUNT_W),
        .LIMIT  (LIMIT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef GUARD_DISPATCH_STALL_EN
        .out_ready(out_ready),
`endif
        .out_valid(out_valid),
        .out_data (out_data),
        .cont     (cont)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Every cycle with out_valid high must match the next queued value.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'(out_valid), 32'd0);
            end else begin
                logic [DATA_W-1:0] exp_v;
                exp_v = sb_q.pop_front();
                check_val("sb_data", 32'(out_data), 32'(exp_v));
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [DATA_W-1:0] d);
        for (int i = 0; i < n; i++) drive(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_cont", 32'(cont), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef GUARD_DISPATCH_STALL_EN
        out_ready = 1'b1;
`endif
        #1;
        check_val("init_valid", 32'(out_valid), 32'd0);
        check_val("init_cont", 32'(cont), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-accumulation, then a partial group must not emit.
        send_n(3, 8'd1);
        do_reset();
        send_n(3, 8'd1);
        idle(3);
        check_val("partial_cont", 32'(cont), 32'd1);
        sb_q.push_back(8'd10);
        send_n(7, 8'd1);
        idle(2);

        // LIMIT group: 10 x 5 -> 50, one cycle after the 10th word.
        sb_q.push_back(8'd50);
        send_n(10, 8'd5);
        check_val("lat_valid", 32'(out_valid), 32'd1);
        check_val("lat_data", 32'(out_data), 32'd50);
        drive(1'b1, 8'd7);
        check_val("emit_one_cycle", 32'(out_valid), 32'd0);
        sb_q.push_back(8'd30);
        send_n(10, 8'd3);
        idle(2);

        // Saturation after three words of 100.
        sb_q.push_back(8'd255);
        send_n(3, 8'd100);
        check_val("sat_valid", 32'(out_valid), 32'd1);
        idle(2);

        // Overflow on the LIMIT word: saturated value wins.
        sb_q.push_back(8'd255);
        send_n(9, 8'd20);
        drive(1'b1, 8'd100);
        idle(2);

        // Zero words count once accumulating.
        sb_q.push_back(8'd1);
        drive(1'b1, 8'd1);
        send_n(9, 8'd0);
        idle(2);

        // Zero in S_START leaves state untouched.
        send_n(3, 8'd0);
        check_val("zero_cont", 32'(cont), 32'd1);
        sb_q.push_back(8'd50);
        send_n(10, 8'd5);
        idle(2);

        // Terminate from S_START, sticky until reset.
        drive(1'b1, 8'h80);
        check_val("term_cont", 32'(cont), 32'd0);
        send_n(12, 8'd5);
        check_val("term_sticky", 32'(cont), 32'd0);
        check_val("term_novalid", 32'(out_valid), 32'd0);
        do_reset();

        // Terminate from S_ACC.
        send_n(3, 8'd1);
        drive(1'b1, 8'h90);
        check_val("term_acc_cont", 32'(cont), 32'd0);
        drive(1'b1, 8'd1);
        do_reset();

        // Gapped group of 2s -> 20.
        sb_q.push_back(8'd20);
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b1, 8'd2);
            if (i < LIMIT - 1) begin
                drive(1'b0, 8'd9);
                drive(1'b0, 8'd9);
            end
        end
        check_val("gap_valid", 32'(out_valid), 32'd1);
        idle(2);

        // Reset while emitting kills the output immediately.
        send_n(10, 8'd1);
        do_reset();
        idle(2);

`ifdef GUARD_DISPATCH_STALL_EN
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) sb_q.push_back(8'd10);
        send_n(10, 8'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("stall_hold", 32'(out_valid), 32'd1);
            drive(1'b1, 8'd9);
        end
        out_ready = 1'b1;
        drive(1'b1, 8'd9);
        check_val("stall_release", 32'(out_valid), 32'd0);
        sb_q.push_back(8'd10);
        send_n(10, 8'd1);
        idle(2);
`endif

        idle(3);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
